// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP detection, 7-bit address match, register pointer byte,
// then auto-incrementing register writes or reads through a host register port.
module i2c_slave_responder #(
  parameter int                             SLAVE_ADDRESS_WIDTH    = 7,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS          = 7'h68,
  parameter int                             REGISTER_ADDRESS_WIDTH = 8,
  parameter int                             DATA_WIDTH             = 8,
  parameter bit                             SHIFT_DIR              = 1'b0
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic                              reg_wr_en,
  output logic                              reg_rd_en,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]             reg_wdata,
  input  logic [DATA_WIDTH-1:0]             reg_rdata,
  output logic                              busy,
  output logic                              txn_done
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t state, state_nxt;

  logic scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]                        cnt, cnt_nxt;
  logic [7:0]                        rx, rx_nxt;
  logic [DATA_WIDTH-1:0]             tx;
  logic [REGISTER_ADDRESS_WIDTH-1:0] ptr, ptr_nxt, addr_nxt;
  logic [DATA_WIDTH-1:0]             wdata_nxt;
  logic rw, rw_nxt, mack, mack_nxt, addressed, addressed_nxt, rd_cap;
  logic oe_nxt, wr_nxt, rd_nxt, busy_nxt, done_nxt;
  logic byte_done, addr_match;

  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b, input logic lsb);
    shift_in = lsb ? {b, r[7:1]} : {r[6:0], b};
  endfunction

  function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] d, input logic [3:0] idx);
    logic [DATA_WIDTH-1:0] sh;
    sh     = SHIFT_DIR ? (d >> idx) : (d << idx);
    tx_bit = SHIFT_DIR ? sh[0] : sh[DATA_WIDTH-1];
  endfunction

  // Pad synchronisers; idle bus level is high so reset to 1 avoids phantom edges
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_d} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {sda_i, sda_m, sda_s};
    end
  end

  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_done  = (cnt == 4'd8);
  assign addr_match = (rx[7:8-SLAVE_ADDRESS_WIDTH] == SLAVE_ADDRESS);

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = IDLE;
    else if (start_det) state_nxt = ADDR;
    else begin
      case (state)
        ADDR:      if (scl_fall && byte_done) state_nxt = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall) state_nxt = rw ? RDATA : REG;
        REG:       if (scl_fall && byte_done) state_nxt = REG_ACK;
        REG_ACK:   if (scl_fall) state_nxt = WDATA;
        WDATA:     if (scl_fall && byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nxt = WDATA;
        RDATA:     if (scl_fall && byte_done) state_nxt = RDATA_ACK;
        RDATA_ACK: if (scl_fall) state_nxt = mack ? RDATA : IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    oe_nxt        = sda_oe;
    cnt_nxt       = cnt;
    rx_nxt        = rx;
    ptr_nxt       = ptr;
    addr_nxt      = reg_addr;
    wdata_nxt     = reg_wdata;
    wr_nxt        = 1'b0;
    rd_nxt        = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    rw_nxt        = rw;
    mack_nxt      = mack;
    addressed_nxt = addressed;
    if (stop_det) begin
      oe_nxt        = 1'b0;
      busy_nxt      = 1'b0;
      done_nxt      = addressed;
      addressed_nxt = 1'b0;
    end else if (start_det) begin
      oe_nxt   = 1'b0;
      busy_nxt = 1'b1;
      cnt_nxt  = 4'd0;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && !byte_done) begin
            rx_nxt  = shift_in(rx, sda_s, (state != ADDR) && SHIFT_DIR);
            cnt_nxt = cnt + 4'd1;
          end
          if (scl_fall && byte_done) begin
            cnt_nxt = 4'd0;
            if (state == ADDR) begin
              if (addr_match) begin
                oe_nxt        = 1'b1;
                rw_nxt        = rx[0];
                addressed_nxt = 1'b1;
                if (rx[0]) begin
                  rd_nxt   = 1'b1;
                  addr_nxt = ptr;
                end
              end
            end else if (state == REG) begin
              oe_nxt  = 1'b1;
              ptr_nxt = REGISTER_ADDRESS_WIDTH'(rx);
            end else begin
              oe_nxt    = 1'b1;
              wr_nxt    = 1'b1;
              addr_nxt  = ptr;
              wdata_nxt = DATA_WIDTH'(rx);
              ptr_nxt   = ptr + REGISTER_ADDRESS_WIDTH'(1);
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            cnt_nxt = 4'd0;
            oe_nxt  = (state == ADDR_ACK && rw) ? ~tx_bit(tx, 4'd0) : 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && !byte_done) cnt_nxt = cnt + 4'd1;
          if (scl_fall) begin
            if (byte_done) begin
              oe_nxt  = 1'b0;
              ptr_nxt = ptr + REGISTER_ADDRESS_WIDTH'(1);
            end else begin
              oe_nxt = ~tx_bit(tx, cnt);
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            mack_nxt = ~sda_s;
            if (!sda_s) begin
              rd_nxt   = 1'b1;
              addr_nxt = ptr;
            end
          end
          if (scl_fall) begin
            cnt_nxt = 4'd0;
            oe_nxt  = mack ? ~tx_bit(tx, 4'd0) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sda_oe    <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      txn_done  <= 1'b0;
      cnt       <= 4'd0;
      ptr       <= '0;
      rw        <= 1'b0;
      mack      <= 1'b0;
      addressed <= 1'b0;
      rd_cap    <= 1'b0;
    end else begin
      sda_oe    <= oe_nxt;
      reg_wr_en <= wr_nxt;
      reg_rd_en <= rd_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      busy      <= busy_nxt;
      txn_done  <= done_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      mack      <= mack_nxt;
      addressed <= addressed_nxt;
      rd_cap    <= reg_rd_en;
    end
  end

  // Read data arrives the cycle after reg_rd_en and is held for the TX byte
  always_ff @(posedge pclk) begin
    rx <= rx_nxt;
    if (rd_cap) tx <= reg_rdata;
  end

endmodule
